// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between the SFR serial-out strobe and the buffered UART.
// The slave side is the transmitter; the master side is the writer that also watches status.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    char_i;
  logic          valid_i;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          busy_o;
  logic          overflow_o;
  logic          uart_tx_o;

  modport master (
    output char_i, valid_i,
    input  full_o, level_o, busy_o, overflow_o, uart_tx_o
  );

  modport slave (
    input  char_i, valid_i,
    output full_o, level_o, busy_o, overflow_o, uart_tx_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: rising edges of the write strobe push into a FIFO,
// and the frame FSM drains it LSB-first at clk/BAUD_DIV with no gap between queued frames.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for BAUD_DIV cycles
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); pops the next byte at its end if one is queued
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input logic          clk,
  input logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          valid_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic push, push_ok, pop, full, empty, baud_end;

  assign push     = bus.valid_i & ~valid_q;
  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign baud_end = (baud_q == '0);
  // A full FIFO still takes a write if the FSM frees a slot on the same edge.
  assign push_ok  = push & (~full | pop);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = BAUD_LAST;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = BAUD_LAST;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            baud_d  = BAUD_LAST;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state one edge later so the output comes straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = shift_q[0];
  end

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q | (push & ~push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      valid_q  <= bus.valid_i;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.char_i;
  end

  assign bus.full_o     = full;
  assign bus.level_o    = level_q;
  assign bus.busy_o     = (state_q != IDLE) | ~empty;
  assign bus.overflow_o = ovf_q;
  assign bus.uart_tx_o  = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=4: a per-cycle vector table
// for a single frame, then hand-written sequences for hold, overflow, reset and full-pop cases.
module tb_uart_tx_fifo;
  localparam int BD = 4;
  localparam int FD = 4;
  localparam int NV = 44;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(FD)) bus ();
  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       valid;
    logic [7:0] ch;
    logic       exp_tx;
    logic       exp_busy;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vt [NV];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a negedge; the strobe is seen by exactly one rising edge.
  task automatic pulse(input logic [7:0] b);
    bus.char_i  = b;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  // Called at the negedge right after the edge where the start bit should appear.
  task automatic check_frame(input logic [7:0] b, input string nm);
    logic [9:0] fb;
    fb = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int good;
      good = 0;
      for (int c = 0; c < BD; c++) begin
        if (bus.uart_tx_o === fb[i]) good++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d samples", nm, i), good, BD);
    end
  endtask

  initial begin
    logic [9:0] fb55;
    int ones, idle_ok;

    fb55 = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < NV; k++) begin
      vt[k].valid     = (k == 0);
      vt[k].ch        = (k == 0) ? 8'h55 : 8'h00;
      vt[k].exp_level = (k == 0) ? 3'd1 : 3'd0;
      vt[k].exp_busy  = (k < 41);
      if (k < 2 || k > 41) vt[k].exp_tx = 1'b1;
      else                 vt[k].exp_tx = fb55[(k - 2) / BD];
    end

    // Test 1: reset state
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.char_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst uart_tx", bus.uart_tx_o, 1);
    chk("rst level", bus.level_o, 0);
    chk("rst busy", bus.busy_o, 0);
    chk("rst full", bus.full_o, 0);
    chk("rst overflow", bus.overflow_o, 0);
    rst = 1'b0;

    // Test 2: single 0x55 frame, cycle by cycle
    for (int k = 0; k < NV; k++) begin
      bus.valid_i = vt[k].valid;
      bus.char_i  = vt[k].ch;
      @(negedge clk);
      chk($sformatf("vec%0d {tx,busy,level}", k),
          {bus.uart_tx_o, bus.busy_o, bus.level_o},
          {vt[k].exp_tx, vt[k].exp_busy, vt[k].exp_level});
    end

    // Test 3: valid held 20 cycles, char changes mid-hold
    bus.char_i  = 8'hA3;
    bus.valid_i = 1'b1;
    @(negedge clk);
    chk("hold level after rise", bus.level_o, 1);
    fork
      begin
        repeat (5) @(negedge clk);
        bus.char_i = 8'h5C;
        repeat (14) @(negedge clk);
        bus.valid_i = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        check_frame(8'hA3, "hold A3");
      end
    join
    chk("hold level end", bus.level_o, 0);
    chk("hold busy end", bus.busy_o, 0);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.uart_tx_o === 1'b1) ones++;
      @(negedge clk);
    end
    chk("hold no second frame", ones, 20);

    // Test 4: six back-to-back pulses into a depth-4 FIFO
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          pulse(8'(i));
          if (i < 6) @(negedge clk);
        end
        chk("burst overflow", bus.overflow_o, 1);
        chk("burst level", bus.level_o, 4);
        chk("burst full", bus.full_o, 1);
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 5; i++) check_frame(8'(i), $sformatf("burst %02h", i));
      end
    join
    chk("burst level end", bus.level_o, 0);
    chk("burst busy end", bus.busy_o, 0);
    chk("burst overflow sticky", bus.overflow_o, 1);

    // Test 5: reset in the middle of a data bit
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2 overflow cleared", bus.overflow_o, 0);
    pulse(8'hF0);
    @(negedge clk);
    pulse(8'h0F);
    repeat (10) @(negedge clk);
    chk("midframe tx low", bus.uart_tx_o, 0);
    chk("midframe level", bus.level_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst tx", bus.uart_tx_o, 1);
    chk("midrst level", bus.level_o, 0);
    chk("midrst busy", bus.busy_o, 0);
    chk("midrst full", bus.full_o, 0);
    idle_ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.uart_tx_o === 1'b1 && bus.busy_o === 1'b0) idle_ok++;
      @(negedge clk);
    end
    chk("midrst stays idle", idle_ok, 60);

    // Test 6: push while full on the stop-end pop edge
    pulse(8'h11);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      pulse(8'(i * 8'h11));
    end
    chk("fullpop level pre", bus.level_o, 4);
    chk("fullpop full pre", bus.full_o, 1);
    repeat (32) @(negedge clk);
    chk("fullpop level before edge", bus.level_o, 4);
    pulse(8'h66);
    chk("fullpop level", bus.level_o, 4);
    chk("fullpop full", bus.full_o, 1);
    chk("fullpop overflow", bus.overflow_o, 0);
    @(negedge clk);
    for (int i = 2; i <= 6; i++) check_frame(8'(i * 8'h11), $sformatf("fullpop %02h", i * 8'h11));
    chk("fullpop level end", bus.level_o, 0);
    chk("fullpop busy end", bus.busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
